// File: rtl/div_unit_param.sv
// Radix-2 restoring integer divider, one quotient bit per cycle, signed or unsigned per operation.
// A start pulse at any time restarts the unit; a zero divisor short-circuits to a one-cycle result.
module div_unit_param #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_ZERO
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH:0]   rem_d;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvd_d;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic             neg_q_q;
  logic             neg_r_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;

  // Magnitudes are plain unsigned WIDTH-bit values, so |MIN_INT| needs no special case.
  always_comb begin
    a_neg = sign_mode & dividend[WIDTH-1];
    b_neg = sign_mode & divisor[WIDTH-1];
    a_abs = a_neg ? -dividend : dividend;
    b_abs = b_neg ? -divisor : divisor;
  end

  // dvd_q doubles as the quotient register: dividend bits leave at the top, quotient bits enter at the bottom.
  always_comb begin
    rem_sh = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    rem_d  = diff[WIDTH] ? rem_sh : diff;
    dvd_d  = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        busy_q  <= 1'b1;
        dbz_q   <= 1'b0;
        neg_q_q <= a_neg ^ b_neg;
        neg_r_q <= a_neg;
        cnt_q   <= '0;
        rem_q   <= '0;
        dvs_q   <= b_abs;
        if (divisor == '0) begin
          state_q <= S_ZERO;
          dvd_q   <= dividend;
        end else begin
          state_q <= S_RUN;
          dvd_q   <= a_abs;
        end
      end else begin
        case (state_q)
          S_RUN: begin
            rem_q <= rem_d;
            dvd_q <= dvd_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) state_q <= S_FIX;
          end
          S_FIX: begin
            q_q     <= neg_q_q ? -dvd_q : dvd_q;
            r_q     <= neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          S_ZERO: begin
            q_q     <= '1;
            r_q     <= dvd_q;
            dbz_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign q    = q_q;
  assign r    = r_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule
